// File: rtl/inst_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Optional statistics are enabled with INST_PREFETCH_STATS_EN.
package inst_prefetch_buf_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam int          PF_DEPTH    = 4;
    localparam logic [31:0] PF_RESET_PC = 32'h0000_0000;
    localparam logic        RSTN_ENABLE = 1'b0;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } pf_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
        if (en && (val != 16'hFFFF)) begin
            return val + 16'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/inst_prefetch_buf_fifo.sv
// Generic synchronous FIFO holding {pc, inst} entries for the prefetch buffer.
// Clear drops all entries; the storage array itself is never reset.
module inst_prefetch_buf_fifo
    import inst_prefetch_buf_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RSTN_ENABLE) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue between the fetch stage and inst_rom.
// Define INST_PREFETCH_STATS_EN to add flush and empty-cycle counters.
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int          DEPTH    = PF_DEPTH,
    parameter logic [31:0] RESET_PC = PF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_rdy_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i
`ifdef INST_PREFETCH_STATS_EN
    ,
    output logic [15:0] flush_cnt_o,
    output logic [15:0] empty_cyc_o
`endif
);

    logic [31:0]           fetch_pc_q, fetch_pc_d;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    pf_entry_t             wr_entry, head_entry;

    assign inst_valid_o = (fifo_count != '0);
    assign pop  = inst_valid_o && fetch_rdy_i && !flush_i;
    // A full queue still accepts a fetch when the head drains in the same cycle.
    assign push = (rst != RSTN_ENABLE) && !flush_i && (!fifo_full || pop);

    assign rom_ce_o   = push;
    assign rom_addr_o = push ? fetch_pc_q : 32'h0;

    assign wr_entry = '{pc: fetch_pc_q, inst: rom_data_i};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (flush_i) begin
            fetch_pc_d = flush_pc_i & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RSTN_ENABLE) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    inst_prefetch_buf_fifo #(
        .WIDTH ($bits(pf_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (flush_i),
        .wr_data   (wr_entry),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_o = fifo_empty ? 32'h0 : head_entry.inst;
    assign pc_o   = fifo_empty ? 32'h0 : head_entry.pc;

`ifdef INST_PREFETCH_STATS_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] empty_cyc_q, empty_cyc_d;

    always_comb begin
        flush_cnt_d = sat_inc16(flush_cnt_q, flush_i);
        empty_cyc_d = sat_inc16(empty_cyc_q, !inst_valid_o);
    end

    always_ff @(posedge clk) begin
        if (rst == RSTN_ENABLE) begin
            flush_cnt_q <= '0;
            empty_cyc_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            empty_cyc_q <= empty_cyc_d;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
    assign empty_cyc_o = empty_cyc_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf; ROM word n holds value n.
// Builds with or without INST_PREFETCH_STATS_EN.
module tb_inst_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_rdy_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
`ifdef INST_PREFETCH_STATS_EN
    logic [15:0] flush_cnt_o;
    logic [15:0] empty_cyc_o;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rom_data_i = rom_addr_o >> 2;

    inst_prefetch_buf dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .fetch_rdy_i  (fetch_rdy_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .rom_ce_o     (rom_ce_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i)
`ifdef INST_PREFETCH_STATS_EN
        ,
        .flush_cnt_o  (flush_cnt_o),
        .empty_cyc_o  (empty_cyc_o)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0; fetch_rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_rom cyc%0d: ce=%b addr=%h, need ce=0 addr=0", k, rom_ce_o, rom_addr_o);
            end
            vectors++;
            if (inst_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_valid cyc%0d: got %b, need 0", k, inst_valid_o);
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL first_fetch: ce=%b addr=%h, need ce=1 addr=0", rom_ce_o, rom_addr_o);
        end
        tick();
        vectors++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
            miscompares++;
            $display("FAIL first_head: v=%b pc=%h inst=%h, need v=1 pc=0 inst=0", inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_steady();
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'(4 * i) || inst_o !== 32'(i)) begin
                miscompares++;
                $display("FAIL steady%0d: v=%b pc=%h inst=%h, need v=1 pc=%h inst=%h",
                         i, inst_valid_o, pc_o, inst_o, 32'(4 * i), 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        flush_i = 1'b1; flush_pc_i = 32'h0; fetch_rdy_i = 1'b0;
        tick();
        flush_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (rom_ce_o !== (k < 4) || rom_addr_o !== ((k < 4) ? 32'(4 * k) : 32'h0)) begin
                miscompares++;
                $display("FAIL stall_fill%0d: ce=%b addr=%h, need ce=%b addr=%h", k, rom_ce_o, rom_addr_o,
                         (k < 4), ((k < 4) ? 32'(4 * k) : 32'h0));
            end
        end
        vectors++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
            miscompares++;
            $display("FAIL stall_head: v=%b pc=%h inst=%h, need v=1 pc=0 inst=0", inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_full_pop();
        fetch_rdy_i = 1'b1;
        #1;
        vectors++;
        if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h10) begin
            miscompares++;
            $display("FAIL full_pop_fetch: ce=%b addr=%h, need ce=1 addr=00000010", rom_ce_o, rom_addr_o);
        end
        tick();
        vectors++;
        if (pc_o !== 32'h4 || inst_o !== 32'h1) begin
            miscompares++;
            $display("FAIL full_pop_head: pc=%h inst=%h, need pc=00000004 inst=00000001", pc_o, inst_o);
        end
        fetch_rdy_i = 1'b0;
        #1;
        vectors++;
        if (rom_ce_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_count: ce=%b, need 0 (queue still full)", rom_ce_o);
        end
        fetch_rdy_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            vectors++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'(4 * i) || inst_o !== 32'(i)) begin
                miscompares++;
                $display("FAIL drain%0d: v=%b pc=%h inst=%h, need v=1 pc=%h inst=%h",
                         i, inst_valid_o, pc_o, inst_o, 32'(4 * i), 32'(i));
            end
        end
    endtask

    task automatic test_flush();
        flush_i = 1'b1; flush_pc_i = 32'h0; fetch_rdy_i = 1'b0;
        tick();
        flush_i = 1'b0;
        repeat (3) tick();
        flush_i = 1'b1; flush_pc_i = 32'h0000_0103; fetch_rdy_i = 1'b1;
        #1;
        vectors++;
        if (rom_ce_o !== 1'b0 || inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_cycle: ce=%b v=%b pc=%h, need ce=0 v=1 pc=0", rom_ce_o, inst_valid_o, pc_o);
        end
        tick();
        flush_i = 1'b0;
        #1;
        vectors++;
        if (inst_valid_o !== 1'b0 || rom_ce_o !== 1'b1 || rom_addr_o !== 32'h100) begin
            miscompares++;
            $display("FAIL flush_refetch: v=%b ce=%b addr=%h, need v=0 ce=1 addr=00000100",
                     inst_valid_o, rom_ce_o, rom_addr_o);
        end
        tick();
        vectors++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== 32'h40) begin
            miscompares++;
            $display("FAIL flush_target: v=%b pc=%h inst=%h, need v=1 pc=00000100 inst=00000040",
                     inst_valid_o, pc_o, inst_o);
        end
        tick();
        vectors++;
        if (pc_o !== 32'h104) begin
            miscompares++;
            $display("FAIL flush_next: pc=%h, need 00000104", pc_o);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF8; fetch_rdy_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (inst_valid_o !== 1'b1 || pc_o !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL wrap%0d: v=%b pc=%h, need v=1 pc=%h", i, inst_valid_o, pc_o, exp_pc[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        fetch_rdy_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0; flush_i = 1'b1; flush_pc_i = 32'h500;
        #1;
        vectors++;
        if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_rom: ce=%b addr=%h, need ce=0 addr=0", rom_ce_o, rom_addr_o);
        end
        tick();
        vectors++;
        if (inst_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_valid: got %b, need 0", inst_valid_o);
        end
`ifdef INST_PREFETCH_STATS_EN
        vectors++;
        if (flush_cnt_o !== 16'h0 || empty_cyc_o !== 16'h0) begin
            miscompares++;
            $display("FAIL stats_reset: flush=%h empty=%h, need 0 0", flush_cnt_o, empty_cyc_o);
        end
`endif
        flush_i = 1'b0; rst = 1'b1; fetch_rdy_i = 1'b1;
        #1;
        vectors++;
        if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_restart: ce=%b addr=%h, need ce=1 addr=0", rom_ce_o, rom_addr_o);
        end
        tick();
        vectors++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_head: v=%b pc=%h inst=%h, need v=1 pc=0 inst=0", inst_valid_o, pc_o, inst_o);
        end
`ifdef INST_PREFETCH_STATS_EN
        vectors++;
        if (flush_cnt_o !== 16'h0 || empty_cyc_o !== 16'h1) begin
            miscompares++;
            $display("FAIL stats_count: flush=%h empty=%h, need 0 1", flush_cnt_o, empty_cyc_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_steady();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
